// File: rtl/mul_div_unit_pkg.sv
// rtl/mul_div_unit_pkg.sv - Shared mul/div op encodings, FSM states and decode helpers
package mul_div_unit_pkg;

    localparam logic [1:0] MD_OP_MULT  = 2'b00;
    localparam logic [1:0] MD_OP_MULTU = 2'b01;
    localparam logic [1:0] MD_OP_DIV   = 2'b10;
    localparam logic [1:0] MD_OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    function automatic logic md_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic md_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/div_iter.sv
// rtl/div_iter.sv - Restoring radix-2 divider core, one quotient bit per step
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dsr_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // The dividend shifts out of quo_q's MSB while quotient bits shift in at the LSB.
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, dsr_q};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem_q <= '0;
            quo_q <= '0;
            dsr_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dsr_q <= divisor;
        end else if (step) begin
            if (trial[WIDTH]) begin
                rem_q <= shifted[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b0};
            end else begin
                rem_q <= trial[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b1};
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - Multi-cycle MULT/MULTU/DIV/DIVU unit producing {HI,LO}
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit DIV0_QUOT = 1'b1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               cancel,
    output logic               busy,
    output logic               result_valid,
    output logic [2*WIDTH-1:0] result,
    output logic               div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    md_state_e state, state_nxt;
    logic [CW-1:0] cnt;
    logic accept, step, last_iter, deliver;

    logic             is_div_r, b_zero_r, neg_res_r, neg_rem_r;
    logic [WIDTH-1:0] a_r, mcand_r, acc_hi_r, acc_lo_r;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] div_quo, div_rem;

    logic [2*WIDTH-1:0] prod, prod_fix, res_nxt;
    logic [WIDTH-1:0]   q_fix, r_fix;

    assign accept    = start & ~cancel & (state != MD_CALC);
    assign busy      = (state == MD_CALC) | accept;
    assign step      = (state == MD_CALC) & ~cancel;
    assign last_iter = (cnt == CW'(WIDTH - 1));
    assign deliver   = (state == MD_DONE) & ~cancel;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= MD_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            MD_IDLE: if (accept) state_nxt = MD_CALC;
            MD_CALC: begin
                if (cancel)         state_nxt = MD_IDLE;
                else if (last_iter) state_nxt = MD_DONE;
            end
            MD_DONE: state_nxt = accept ? MD_CALC : MD_IDLE;
            default: state_nxt = MD_IDLE;
        endcase
    end

    // Both cores iterate on magnitudes; signs are reapplied in the DONE cycle.
    assign a_abs = (md_is_signed(op) & a[WIDTH-1]) ? -a : a;
    assign b_abs = (md_is_signed(op) & b[WIDTH-1]) ? -b : b;

    assign mul_sum = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, mcand_r} : '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt       <= '0;
            is_div_r  <= 1'b0;
            b_zero_r  <= 1'b0;
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            a_r       <= '0;
            mcand_r   <= '0;
            acc_hi_r  <= '0;
            acc_lo_r  <= '0;
        end else if (accept) begin
            cnt       <= '0;
            is_div_r  <= md_is_div(op);
            b_zero_r  <= (b == '0);
            neg_res_r <= md_is_signed(op) & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem_r <= md_is_signed(op) & a[WIDTH-1];
            a_r       <= a;
            mcand_r   <= a_abs;
            acc_hi_r  <= '0;
            acc_lo_r  <= b_abs;
        end else if (step) begin
            cnt      <= cnt + 1'b1;
            acc_hi_r <= mul_sum[WIDTH:1];
            acc_lo_r <= {mul_sum[0], acc_lo_r[WIDTH-1:1]};
        end
    end

    div_iter #(.WIDTH(WIDTH)) u_div_iter (
        .clk       (clk),
        .resetn    (resetn),
        .load      (accept),
        .step      (step),
        .dividend  (a_abs),
        .divisor   (b_abs),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        prod     = {acc_hi_r, acc_lo_r};
        prod_fix = neg_res_r ? -prod : prod;
        q_fix    = neg_res_r ? -div_quo : div_quo;
        r_fix    = neg_rem_r ? -div_rem : div_rem;
        if (b_zero_r) begin
            q_fix = {WIDTH{DIV0_QUOT}};
            r_fix = a_r;
        end
        res_nxt = is_div_r ? {r_fix, q_fix} : prod_fix;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            result_valid <= 1'b0;
            result       <= '0;
            div_by_zero  <= 1'b0;
        end else begin
            result_valid <= deliver;
            if (deliver) begin
                result      <= res_nxt;
                div_by_zero <= is_div_r & b_zero_r;
            end
        end
    end

endmodule
